i_decode: RTL and testbench

I_DECODE -- requirements
Module: i_decode

---
 rtl/i_decode.sv | 144 ++++++++++++++
 tb/tb_i_decode.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/i_decode.sv
// IF/ID latch, register file and control decode; REGFILE_BYPASS_EN forwards same-cycle writeback to reads.
// One cycle from fetch to decoded outputs; stall holds the latch, flush (which overrides stall) loads a bubble.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module i_decode #(
  parameter logic [`WORD-1:0] SP_INIT = `WORD'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [`INSTR_LEN-1:0] instruction_in,
  input  logic [`WORD-1:0]      pc_in,
  input  logic                  wb_en,
  input  logic [4:0]            wb_addr,
  input  logic [`WORD-1:0]      wb_data,
  output logic [`WORD-1:0]      dec_pc,
  output logic [10:0]           opcode,
  output logic [`WORD-1:0]      read_data1,
  output logic [`WORD-1:0]      read_data2,
  output logic [`WORD-1:0]      sign_ext,
  output logic                  reg2_loc,
  output logic                  alu_src,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  branch,
  output logic                  uncond_branch,
  output logic [1:0]            alu_op,
  output logic                  valid,
  output logic                  illegal
);

  logic [`INSTR_LEN-1:0] instr_q;
  logic [`WORD-1:0]      pc_q;
  logic                  valid_q;
  logic [`WORD-1:0]      regs [32];
  logic [10:0]           op;
  logic                  dec_en;
  logic [4:0]            ra [2];
  logic [`WORD-1:0]      rdat [2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      instr_q <= instruction_in;
      pc_q    <= pc_in;
      valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 28) ? SP_INIT : '0;
    end else if (wb_en && wb_addr != 5'd31) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign op     = instr_q[31:21];
  assign dec_en = valid_q && reset;
  assign valid  = dec_en;
  assign dec_pc = pc_q;
  assign opcode = reset ? op : 11'd0;

  always_comb begin
    reg2_loc      = 1'b0;
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    branch        = 1'b0;
    uncond_branch = 1'b0;
    alu_op        = 2'b00;
    illegal       = 1'b0;
    sign_ext      = '0;
    if (dec_en) begin
      if (op == 11'b10001011000 || op == 11'b11001011000 ||
          op == 11'b10001010000 || op == 11'b10101010000) begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
        sign_ext  = {{(`WORD-6){1'b0}}, instr_q[15:10]};
      end else if (op == 11'b11111000010) begin
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        mem_read   = 1'b1;
        sign_ext   = {{(`WORD-9){instr_q[20]}}, instr_q[20:12]};
      end else if (op == 11'b11111000000) begin
        reg2_loc  = 1'b1;
        alu_src   = 1'b1;
        mem_write = 1'b1;
        sign_ext  = {{(`WORD-9){instr_q[20]}}, instr_q[20:12]};
      end else if (op[10:3] == 8'b10110100) begin
        reg2_loc = 1'b1;
        branch   = 1'b1;
        alu_op   = 2'b01;
        sign_ext = {{(`WORD-19){instr_q[23]}}, instr_q[23:5]};
      end else if (op[10:5] == 6'b000101) begin
        uncond_branch = 1'b1;
        alu_op        = 2'b01;
        sign_ext      = {{(`WORD-26){instr_q[25]}}, instr_q[25:0]};
      end else begin
        illegal = 1'b1;
      end
    end
  end

  // While reset is held the reads show the values the file is being cleared to.
  always_comb begin
    ra[0] = instr_q[9:5];
    ra[1] = reg2_loc ? instr_q[4:0] : instr_q[20:16];
    for (int k = 0; k < 2; k++) begin
      if (!reset)
        rdat[k] = (ra[k] == 5'd28) ? SP_INIT : '0;
      else if (ra[k] == 5'd31)
        rdat[k] = '0;
`ifdef REGFILE_BYPASS_EN
      else if (wb_en && wb_addr == ra[k])
        rdat[k] = wb_data;
`endif
      else
        rdat[k] = regs[ra[k]];
    end
  end

  assign read_data1 = rdat[0];
  assign read_data2 = rdat[1];

endmodule

// File: tb/tb_i_decode.sv
// Bench for i_decode: reference model of latch, register file and decode table, plus directed literal checks.
module tb_i_decode;

  localparam logic [63:0] SP = 64'h0000_0000_0000_8000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] instruction_in;
  logic [63:0] pc_in;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic [63:0] dec_pc;
  logic [10:0] opcode;
  logic [63:0] read_data1;
  logic [63:0] read_data2;
  logic [63:0] sign_ext;
  logic        reg2_loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, uncond_branch;
  logic [1:0]  alu_op;
  logic        valid;
  logic        illegal;

  i_decode #(.SP_INIT(SP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .instruction_in(instruction_in), .pc_in(pc_in),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .dec_pc(dec_pc), .opcode(opcode), .read_data1(read_data1), .read_data2(read_data2),
    .sign_ext(sign_ext), .reg2_loc(reg2_loc), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .uncond_branch(uncond_branch), .alu_op(alu_op), .valid(valid), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  wire [9:0] ctrl = {reg2_loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                     branch, uncond_branch, alu_op};

  // Reference model state
  logic [31:0] m_instr;
  logic [63:0] m_pc;
  logic        m_valid;
  logic [63:0] m_regs [32];
  bit          m_init = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_instr = 0; m_pc = 0; m_valid = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      m_regs[28] = SP;
      m_init = 1;
    end else begin
      if (wb_en && wb_addr != 31) m_regs[wb_addr] = wb_data;
      if (flush) begin
        m_instr = 0; m_pc = 0; m_valid = 0;
      end else if (!stall) begin
        m_instr = instruction_in; m_pc = pc_in; m_valid = 1;
      end
    end
  end

  // Control table ordering: reg2_loc alu_src mem_to_reg reg_write mem_read mem_write branch uncond alu_op[1:0]
  function automatic void ref_decode(input logic [31:0] i, output logic [9:0] c,
                                     output logic ill, output logic [63:0] imm);
    logic signed [8:0]  d9;
    logic signed [18:0] c19;
    logic signed [25:0] b26;
    d9 = i[20:12]; c19 = i[23:5]; b26 = i[25:0];
    ill = 0; imm = 0;
    casez (i[31:21])
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
        c = 10'b0001000010; imm = 64'(i[15:10]);
      end
      11'b11111000010: begin c = 10'b0111100000; imm = 64'(d9); end
      11'b11111000000: begin c = 10'b1100010000; imm = 64'(d9); end
      11'b10110100???: begin c = 10'b1000001001; imm = 64'(c19); end
      11'b000101?????: begin c = 10'b0000000101; imm = 64'(b26); end
      default:         begin c = 10'b0; ill = 1; end
    endcase
  endfunction

  function automatic logic [63:0] ref_read(input logic [4:0] a);
    if (!reset) return (a == 28) ? SP : 64'h0;
    if (a == 31) return 64'h0;
`ifdef REGFILE_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return m_regs[a];
  endfunction

  always @(negedge clk) begin
    if (m_init) begin
      logic [9:0]  ec;
      logic        eill;
      logic [63:0] eimm;
      logic        ev;
      ev = m_valid && reset;
      ref_decode(m_instr, ec, eill, eimm);
      if (!ev) begin ec = 0; eill = 0; eimm = 0; end
      check("cyc_valid", {63'd0, valid}, {63'd0, ev});
      check("cyc_ctrl", {53'd0, illegal, ctrl}, {53'd0, eill, ec});
      check("cyc_imm", sign_ext, eimm);
      check("cyc_pc", dec_pc, m_pc);
      check("cyc_opcode", {53'd0, opcode}, reset ? {53'd0, m_instr[31:21]} : 64'd0);
      check("cyc_rd1", read_data1, ref_read(m_instr[9:5]));
      check("cyc_rd2", read_data2, ref_read(ec[9] ? m_instr[4:0] : m_instr[20:16]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0; stall = 0; flush = 0; instruction_in = 0; pc_in = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    tick(); tick();
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_ctrl", {53'd0, illegal, ctrl}, 64'd0);
    check("rst_rd1", read_data1, 64'd0);

    // ADD X0, X5, X28 : read X5 and X28 straight after reset
    reset = 1; instruction_in = 32'h8B1C00A0; pc_in = 64'h4;
    tick();
    check("x5_zero", read_data1, 64'd0);
    check("x28_sp", read_data2, SP);
    check("pc4", dec_pc, 64'h4);

    wb_en = 1; wb_addr = 3; wb_data = 64'h10; tick();
    wb_addr = 4; wb_data = 64'h20; tick();
    wb_en = 0; instruction_in = 32'h8B040061; pc_in = 64'h8;
    tick();
    check("add_rd1", read_data1, 64'h10);
    check("add_rd2", read_data2, 64'h20);
    check("add_ctrl", {54'd0, ctrl}, 64'b0001000010);
    check("add_pc", dec_pc, 64'h8);

    instruction_in = 32'hF85F8062; pc_in = 64'hC;
    tick();
    check("ldur_imm", sign_ext, 64'hFFFF_FFFF_FFFF_FFF8);
    check("ldur_ctrl", {54'd0, ctrl}, 64'b0111100000);
    check("ldur_rd1", read_data1, 64'h10);

    stall = 1; flush = 1; instruction_in = 32'hF8010064; pc_in = 64'h10;
    tick();
    check("sf_valid", {63'd0, valid}, 64'd0);
    check("sf_ctrl", {54'd0, ctrl}, 64'd0);
    check("sf_pc", dec_pc, 64'd0);
    stall = 0; flush = 0;
    tick();
    check("stur_ctrl", {54'd0, ctrl}, 64'b1100010000);
    check("stur_imm", sign_ext, 64'd16);
    check("stur_rd2", read_data2, 64'h20);

    stall = 1; instruction_in = 32'hFFFFFFFF; wb_en = 1; wb_addr = 9; wb_data = 64'h99;
    tick();
    check("hold_ctrl", {54'd0, ctrl}, 64'b1100010000);
    check("hold_pc", dec_pc, 64'h10);
    stall = 0; wb_en = 0;

    // ADD X0, X31, X7 with a write to X31 in flight
    instruction_in = 32'h8B0703E0; pc_in = 64'h20; wb_en = 1; wb_addr = 31; wb_data = 64'hFF;
    tick();
    check("x31_rd1", read_data1, 64'd0);
    stall = 1; wb_addr = 7; wb_data = 64'h77;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x7_same_cycle", read_data2, 64'h77);
`else
    check("x7_same_cycle", read_data2, 64'h0);
`endif
    tick();
    wb_en = 0;
    #1;
    check("x7_next_cycle", read_data2, 64'h77);
    check("x31_still_zero", read_data1, 64'd0);

    stall = 0; instruction_in = 32'hFFFFFFFF;
    tick();
    check("ill_flag", {63'd0, illegal}, 64'd1);
    check("ill_ctrl", {54'd0, ctrl}, 64'd0);
    check("ill_imm", sign_ext, 64'd0);

    instruction_in = 32'hB4FFFFE5;
    tick();
    check("cbz_ctrl", {54'd0, ctrl}, 64'b1000001001);
    check("cbz_imm", sign_ext, 64'hFFFF_FFFF_FFFF_FFFF);

    instruction_in = 32'h14000002;
    tick();
    check("b_ctrl", {54'd0, ctrl}, 64'b0000000101);
    check("b_imm", sign_ext, 64'd2);

    instruction_in = 32'h8B040061;
    tick();
    reset = 0; wb_en = 1; wb_addr = 3; wb_data = 64'h55; stall = 1;
    #1;
    check("mid_rst_gate", {53'd0, valid, ctrl}, 64'd0);
    tick();
    check("mid_rst_valid", {63'd0, valid}, 64'd0);
    check("mid_rst_pc", dec_pc, 64'd0);
    reset = 1; wb_en = 0; stall = 0;
    tick();
    check("post_rst_rd1", read_data1, 64'd0);
    check("post_rst_rd2", read_data2, 64'd0);
    check("post_rst_ctrl", {54'd0, ctrl}, 64'b0001000010);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
